// File: rtl/z80_pkg.sv
// Shared Z80 fetch/decode definitions: prefix bytes, fetch FSM states and
// opcode-length helpers used by the length decoder and the disassembler.
package z80_pkg;

  localparam logic [7:0] PFX_CB = 8'hCB;
  localparam logic [7:0] PFX_ED = 8'hED;
  localparam logic [7:0] PFX_DD = 8'hDD;
  localparam logic [7:0] PFX_FD = 8'hFD;
  localparam int MAX_ILEN = 4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetch_state_t;

  function automatic logic [2:0] base_len(input logic [7:0] op);
    case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hD3, 8'hDB, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38:
        base_len = 3'd2;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h22, 8'h2A, 8'h32, 8'h3A,
      8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4,
      8'hDA, 8'hDC, 8'hE2, 8'hE4, 8'hEA, 8'hEC, 8'hF2, 8'hF4,
      8'hFA, 8'hFC:
        base_len = 3'd3;
      default:
        base_len = 3'd1;
    endcase
  endfunction

  // Opcodes that gain a displacement byte when IX/IY replaces (HL).
  function automatic logic is_hl_mem(input logic [7:0] op);
    case (op)
      8'h34, 8'h35, 8'h36, 8'h46, 8'h4E, 8'h56, 8'h5E, 8'h66, 8'h6E,
      8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h77, 8'h7E,
      8'h86, 8'h8E, 8'h96, 8'h9E, 8'hA6, 8'hAE, 8'hB6, 8'hBE:
        is_hl_mem = 1'b1;
      default:
        is_hl_mem = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/z80_ilen.sv
// Combinational Z80 instruction-length decoder: len from the first two bytes,
// need = how many bytes must be present before len is meaningful.
module z80_ilen
  import z80_pkg::*;
(
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  output logic [2:0] len,
  output logic [1:0] need
);

  logic [3:0] ix_len;

  always_comb begin
    len    = base_len(q0);
    need   = 2'd1;
    ix_len = '0;
    case (q0)
      PFX_CB: begin
        len  = 3'd2;
        need = 2'd2;
      end
      PFX_ED: begin
        need = 2'd2;
        len  = (q1 inside {8'h43, 8'h4B, 8'h53, 8'h5B, 8'h63, 8'h6B, 8'h73, 8'h7B})
               ? 3'd4 : 3'd2;
      end
      PFX_DD, PFX_FD: begin
        need = 2'd2;
        if (q1 == PFX_CB) begin
          len = 3'(MAX_ILEN);
        end else begin
          ix_len = 4'd1 + {1'b0, base_len(q1)} + {3'b000, is_hl_mem(q1)};
          len    = (ix_len > 4'(MAX_ILEN)) ? 3'(MAX_ILEN) : ix_len[2:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_fetch_decode.sv
// Byte-wide Z80 fetch unit: prefetch queue fed one byte per memory request,
// presents one whole instruction per cycle and flushes on a taken branch.
module z80_fetch_decode
  import z80_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int AW     = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [AW-1:0] archPC,
  input  logic          PCupdate,
  input  logic          ex_stall,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [7:0]    mem_rdata,
  output logic [31:0]   instr,
  output logic          instr_valid,
  output logic [2:0]    PC_disp,
  output logic          pipe_stall
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [QDEPTH*8-1:0] qbuf, qbuf_nxt;
  logic [CW-1:0]       count, count_nxt, consumed;
  logic [AW-1:0]       addr_nxt;
  fetch_state_t        state, state_nxt;
  logic [2:0]          len;
  logic [1:0]          need;
  logic                consume, redirect, append, discard;

  z80_ilen u_ilen (
    .q0   (qbuf[7:0]),
    .q1   (qbuf[15:8]),
    .len  (len),
    .need (need)
  );

  assign instr_valid = (count >= CW'(need)) && (count >= CW'(len));
  assign pipe_stall  = ex_stall | ~instr_valid;
  assign PC_disp     = instr_valid ? len : 3'd0;
  assign consume     = instr_valid & ~ex_stall;
  assign redirect    = PCupdate & ~pipe_stall;
  assign consumed    = consume ? CW'(len) : '0;
  assign mem_req     = (state != IDLE);
  assign discard     = (state == DISCARD);
  // A redirect in the ack cycle empties the queue, so that byte is dropped too.
  assign append      = mem_ack & mem_req & ~discard & ~redirect;

  always_comb begin
    instr = '0;
    for (int i = 0; i < MAX_ILEN; i++) begin
      if (instr_valid && (i < int'(len))) instr[i*8 +: 8] = qbuf[i*8 +: 8];
    end
  end

  always_comb begin
    qbuf_nxt  = qbuf >> {consumed, 3'b000};
    count_nxt = count - consumed;
    if (append) begin
      qbuf_nxt[int'(count_nxt)*8 +: 8] = mem_rdata;
      count_nxt = count_nxt + 1'b1;
    end
    if (redirect) count_nxt = '0;
  end

  // Request FSM: one byte in flight; archPC+count is invariant under consume.
  always_comb begin
    state_nxt = state;
    addr_nxt  = mem_addr;
    case (state)
      IDLE: begin
        if (!redirect && (count < CW'(QDEPTH))) begin
          state_nxt = REQ;
          addr_nxt  = archPC + AW'(count);
        end
      end
      REQ: begin
        if (mem_ack)       state_nxt = IDLE;
        else if (redirect) state_nxt = DISCARD;
      end
      DISCARD: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      mem_addr <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      mem_addr <= addr_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    qbuf <= qbuf_nxt;
  end

endmodule

// File: tb/tb_z80_fetch_decode.sv
// Bench for z80_fetch_decode: memory responder, PC updater model and an
// instruction scoreboard, driven by one task per scenario.
module tb_z80_fetch_decode;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] archPC;
  logic        PCupdate;
  logic        ex_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [2:0]  PC_disp;
  logic        pipe_stall;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  len;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] addr_log[$];
  logic [7:0]  mem [0:65535];
  int          ack_lat = 0;
  logic [15:0] pc_init = 16'h0000;
  logic [15:0] target  = 16'h0000;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 CLK = ~CLK;

  z80_fetch_decode dut (
    .CLK         (CLK),
    .RST         (RST),
    .archPC      (archPC),
    .PCupdate    (PCupdate),
    .ex_stall    (ex_stall),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .PC_disp     (PC_disp),
    .pipe_stall  (pipe_stall)
  );

  // Memory: logs each new request address, acks after ack_lat idle negedges.
  initial begin : responder
    int   wait_ctr;
    logic req_seen;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    wait_ctr  = 0;
    req_seen  = 1'b0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!req_seen) begin
          addr_log.push_back(mem_addr);
          req_seen = 1'b1;
        end
        if (wait_ctr >= ack_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
        end else begin
          wait_ctr++;
        end
      end else begin
        wait_ctr = 0;
        req_seen = 1'b0;
      end
    end
  end

  // PC updater: loads target on accepted redirect, else advances by PC_disp.
  initial begin : pc_updater
    logic        s_rst, s_redir, s_cons;
    logic [2:0]  s_disp;
    logic [15:0] s_tgt;
    archPC = 16'h0000;
    forever begin
      @(negedge CLK);
      #2;
      s_rst   = RST;
      s_redir = PCupdate & ~pipe_stall;
      s_cons  = instr_valid & ~ex_stall;
      s_disp  = PC_disp;
      s_tgt   = target;
      @(posedge CLK);
      #1;
      if (s_rst)        archPC = pc_init;
      else if (s_redir) archPC = s_tgt;
      else if (s_cons)  archPC = archPC + 16'(s_disp);
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (!RST && instr_valid && !ex_stall) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL sb_extra: got instr %h len %0d, expected no instruction", instr, PC_disp);
        end else begin
          e = sb.pop_front();
          if (instr !== e.ins || PC_disp !== e.len)
            $display("FAIL sb_instr: got %h len %0d, expected %h len %0d",
                     instr, PC_disp, e.ins, e.len);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic push_exp(input logic [31:0] ins, input logic [2:0] len);
    exp_t e;
    e.ins = ins;
    e.len = len;
    sb.push_back(e);
  endtask

  task automatic do_reset(input logic [15:0] pc, input int lat);
    @(negedge CLK);
    RST      = 1'b1;
    ex_stall = 1'b1;
    PCupdate = 1'b0;
    pc_init  = pc;
    target   = pc;
    ack_lat  = lat;
    repeat (3) @(negedge CLK);
    #1;
    sb.delete();
    addr_log.delete();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int cyc = 0;
    while (sb.size() != 0 && cyc < budget) begin
      @(negedge CLK);
      cyc++;
    end
    ex_stall = 1'b1;
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL %s_timeout: got %0d instructions outstanding, expected 0", name, sb.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    clear_mem();
    @(negedge CLK);
    RST = 1'b1; ex_stall = 1'b1; PCupdate = 1'b0;
    pc_init = 16'h0000; target = 16'h0000; ack_lat = 50;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b expected 0", mem_req); else n_pass++;
    n_checks++; if (pipe_stall !== 1'b1) $display("FAIL rst_pipe_stall: got %b expected 1", pipe_stall); else n_pass++;
    n_checks++; if (PC_disp !== 3'd0) $display("FAIL rst_pc_disp: got %0d expected 0", PC_disp); else n_pass++;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", instr_valid); else n_pass++;
    n_checks++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h expected 0", instr); else n_pass++;
    sb.delete();
    addr_log.delete();
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    #1;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rst_first_req: got %b expected 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0000) $display("FAIL rst_first_addr: got %h expected 0000", mem_addr); else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    #1;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_midtxn_req: got %b expected 0", mem_req); else n_pass++;
  endtask

  task automatic test_stream();
    clear_mem();
    do_reset(16'h0000, 0);
    for (int i = 0; i < 6; i++) push_exp(32'h0, 3'd1);
    ex_stall = 1'b0;
    drain("stream", 200);
    for (int i = 0; i < addr_log.size(); i++) begin
      n_checks++;
      if (addr_log[i] !== 16'(i))
        $display("FAIL stream_addr%0d: got %h expected %h", i, addr_log[i], 16'(i));
      else
        n_pass++;
    end
    n_checks++;
    if (addr_log.size() < 6) $display("FAIL stream_nreq: got %0d requests expected >= 6", addr_log.size());
    else n_pass++;
  endtask

  task automatic test_length();
    logic [7:0] prog [0:16];
    int cyc = 0;
    prog = '{8'h21, 8'h34, 8'h12,
             8'hDD, 8'h36, 8'h05, 8'h7F,
             8'hFD, 8'hCB, 8'h02, 8'h46,
             8'hED, 8'h4B, 8'h00, 8'hC0,
             8'hCB, 8'h11};
    clear_mem();
    for (int i = 0; i < 17; i++) mem[i] = prog[i];
    do_reset(16'h0000, 1);
    push_exp(32'h0012_3421, 3'd3);
    push_exp(32'h7F05_36DD, 3'd4);
    push_exp(32'h4602_CBFD, 3'd4);
    push_exp(32'hC000_4BED, 3'd4);
    push_exp(32'h0000_11CB, 3'd2);
    while (sb.size() != 0 && cyc < 400) begin
      @(negedge CLK);
      cyc++;
      ex_stall = ($urandom_range(0, 3) == 0);
    end
    drain("length", 0);
  endtask

  task automatic test_redirect();
    int cyc = 0;
    logic [15:0] a5, a6;
    clear_mem();
    mem[16'h0003] = 8'h76; mem[16'h0004] = 8'h76;
    mem[16'h0005] = 8'hC3; mem[16'h0006] = 8'hC3;
    mem[16'h0100] = 8'h3E; mem[16'h0101] = 8'h55;
    do_reset(16'h0000, 2);
    repeat (24) @(negedge CLK);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0000_553E, 3'd2);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0, 3'd1);
    ex_stall = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    ex_stall = 1'b1;
    while (!(mem_req && mem_addr == 16'h0005) && cyc < 40) begin
      @(negedge CLK);
      cyc++;
    end
    n_checks++;
    if (!(mem_req && mem_addr == 16'h0005)) $display("FAIL redir_wait: got addr %h req %b expected 0005 pending", mem_addr, mem_req);
    else n_pass++;
    PCupdate = 1'b1; target = 16'h0100; ex_stall = 1'b0;
    #1;
    n_checks++; if (pipe_stall !== 1'b0) $display("FAIL redir_accept: got pipe_stall %b expected 0", pipe_stall); else n_pass++;
    @(negedge CLK);
    PCupdate = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0) $display("FAIL redir_stale: got valid %b expected 0", instr_valid); else n_pass++;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL redir_hold_req: got %b expected 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 16'h0005) $display("FAIL redir_hold_addr: got %h expected 0005", mem_addr); else n_pass++;
    drain("redirect", 100);
    a5 = (addr_log.size() > 6) ? addr_log[5] : 16'hxxxx;
    a6 = (addr_log.size() > 6) ? addr_log[6] : 16'hxxxx;
    n_checks++; if (a5 !== 16'h0005) $display("FAIL redir_addr5: got %h expected 0005", a5); else n_pass++;
    n_checks++; if (a6 !== 16'h0100) $display("FAIL redir_new_addr: got %h expected 0100", a6); else n_pass++;
  endtask

  task automatic test_back_pressure();
    clear_mem();
    mem[16'h0200] = 8'h01; mem[16'h0201] = 8'h34; mem[16'h0202] = 8'h12;
    do_reset(16'h0200, 0);
    repeat (14) @(negedge CLK);
    n_checks++;
    if (addr_log.size() != 4) $display("FAIL bp_nreq: got %0d requests expected 4", addr_log.size());
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      n_checks++; if (mem_req !== 1'b0) $display("FAIL bp_req%0d: got %b expected 0", i, mem_req); else n_pass++;
      n_checks++; if (instr !== 32'h0012_3401) $display("FAIL bp_instr%0d: got %h expected 00123401", i, instr); else n_pass++;
      n_checks++; if (PC_disp !== 3'd3) $display("FAIL bp_disp%0d: got %0d expected 3", i, PC_disp); else n_pass++;
    end
    push_exp(32'h0012_3401, 3'd3);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0, 3'd1);
    @(negedge CLK);
    ex_stall = 1'b0;
    drain("bp", 100);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [0:2];
    logic [15:0] got;
    exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
    clear_mem();
    mem[16'hFFFE] = 8'hC3; mem[16'hFFFF] = 8'h00; mem[16'h0000] = 8'h80;
    do_reset(16'hFFFE, 0);
    push_exp(32'h0080_00C3, 3'd3);
    push_exp(32'h0, 3'd1);
    push_exp(32'h0, 3'd1);
    ex_stall = 1'b0;
    drain("wrap", 100);
    for (int i = 0; i < 3; i++) begin
      got = (addr_log.size() > i) ? addr_log[i] : 16'hxxxx;
      n_checks++;
      if (got !== exp_a[i]) $display("FAIL wrap_addr%0d: got %h expected %h", i, got, exp_a[i]);
      else n_pass++;
    end
  endtask

  initial begin
    RST = 1'b1; PCupdate = 1'b0; ex_stall = 1'b1;
    test_reset();
    test_stream();
    test_length();
    test_redirect();
    test_back_pressure();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
